// File: rtl/ws2812_rx.sv
// WS2812 serial receiver: decodes pulse-width bits into pixel words with a ready/valid handshake.
// Define WS2812_RX_FWD_EN to forward the line on dout after the first word of each frame.
module ws2812_rx #(
    parameter int unsigned CLK_FRE      = 27_000_000,
    parameter int unsigned WS2812_WIDTH = 24,
    parameter int unsigned T_THRESH     = CLK_FRE / 1_000_000 * 6 / 10,
    parameter int unsigned T_MIN_HIGH   = CLK_FRE / 10_000_000,
    parameter int unsigned T_MAX_HIGH   = CLK_FRE / 1_000_000 * 2,
    parameter int unsigned T_RESET      = CLK_FRE / 1_000_000 * 50
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    din,
    output logic [WS2812_WIDTH-1:0] pixel,
    output logic                    pixel_valid,
    input  logic                    pixel_ready,
    output logic [8:0]              pixel_idx,
    output logic                    frame_end,
    output logic                    overflow,
    output logic                    bit_err,
    output logic                    dout
);
    localparam int unsigned CntMax = (T_RESET > T_MAX_HIGH) ? T_RESET : T_MAX_HIGH;
    localparam int unsigned CW     = $clog2(CntMax + 1);
    localparam int unsigned BW     = $clog2(WS2812_WIDTH + 1);

    typedef enum logic [1:0] {StSync, StIdle, StHigh, StLow} state_e;

    state_e                  state_q;
    logic                    din_meta_q;
    logic                    din_sync_q;
    logic [CW-1:0]           cnt_q;
    logic [BW-1:0]           bit_cnt_q;
    logic [WS2812_WIDTH-1:0] shift_q;

    logic                    bit_one;
    logic                    bit_ok;
    logic                    word_done;
    logic                    err_det;
    logic                    gap_det;
    logic [WS2812_WIDTH-1:0] shift_next;

    always_comb begin
        bit_one    = (cnt_q >= CW'(T_THRESH));
        // Falling edge after a high pulse long enough to be a real bit
        bit_ok     = (state_q == StHigh) && !din_sync_q && (cnt_q >= CW'(T_MIN_HIGH));
        shift_next = {bit_one, shift_q[WS2812_WIDTH-1:1]};
        word_done  = bit_ok && (bit_cnt_q == BW'(WS2812_WIDTH - 1));
        err_det    = (state_q == StHigh) && din_sync_q && (cnt_q >= CW'(T_MAX_HIGH));
        gap_det    = (state_q == StLow) && !din_sync_q && (cnt_q == CW'(T_RESET - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_meta_q  <= 1'b0;
            din_sync_q  <= 1'b0;
            state_q     <= StSync;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            pixel       <= '0;
            pixel_valid <= 1'b0;
            pixel_idx   <= '0;
            frame_end   <= 1'b0;
            overflow    <= 1'b0;
            bit_err     <= 1'b0;
        end else begin
            din_meta_q <= din;
            din_sync_q <= din_meta_q;
            frame_end  <= 1'b0;
            if (pixel_valid && pixel_ready) pixel_valid <= 1'b0;
            unique case (state_q)
                StSync: begin
                    if (din_sync_q) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CW'(T_RESET - 1)) begin
                        cnt_q   <= '0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StIdle: begin
                    if (din_sync_q) begin
                        state_q <= StHigh;
                        cnt_q   <= CW'(1);
                    end
                end
                StHigh: begin
                    if (err_det) begin
                        bit_err   <= 1'b1;
                        state_q   <= StSync;
                        cnt_q     <= '0;
                        bit_cnt_q <= '0;
                    end else if (din_sync_q) begin
                        cnt_q <= cnt_q + 1'b1;
                    end else begin
                        state_q <= StLow;
                        cnt_q   <= CW'(1);
                        if (bit_ok) begin
                            shift_q <= shift_next;
                            if (word_done) begin
                                pixel       <= shift_next;
                                pixel_valid <= 1'b1;
                                bit_cnt_q   <= '0;
                                if (pixel_valid && !pixel_ready) overflow <= 1'b1;
                                if (pixel_idx != 9'd511) pixel_idx <= pixel_idx + 1'b1;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                            end
                        end
                    end
                end
                StLow: begin
                    if (din_sync_q) begin
                        state_q <= StHigh;
                        cnt_q   <= CW'(1);
                    end else if (gap_det) begin
                        state_q   <= StIdle;
                        cnt_q     <= '0;
                        bit_cnt_q <= '0;
                        frame_end <= 1'b1;
                        pixel_idx <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StSync;
            endcase
        end
    end

`ifdef WS2812_RX_FWD_EN
    // Opens once this stage has taken its own word; closes at frame end or on a line error
    logic fwd_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_q <= 1'b0;
            dout  <= 1'b0;
        end else begin
            dout <= din_sync_q & fwd_q;
            if (gap_det || err_det) fwd_q <= 1'b0;
            else if (word_done)     fwd_q <= 1'b1;
        end
    end
`else
    assign dout = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812_rx.sv
// Randomized bench for ws2812_rx checked against a frame-level reference model.
module tb_ws2812_rx;
    localparam int unsigned W   = 24;
    localparam int          GAP = 1400;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         din = 1'b0;
    logic         pixel_ready = 1'b0;
    logic [W-1:0] pixel;
    logic         pixel_valid;
    logic [8:0]   pixel_idx;
    logic         frame_end;
    logic         overflow;
    logic         bit_err;
    logic         dout;

    ws2812_rx dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .pixel      (pixel),
        .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready),
        .pixel_idx  (pixel_idx),
        .frame_end  (frame_end),
        .overflow   (overflow),
        .bit_err    (bit_err),
        .dout       (dout)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_pass   = 0;
    int           fe_cnt   = 0;
    int           dout_hi  = 0;
    logic [W-1:0] acc_q[$];
    logic [W-1:0] exp_q[$];
    logic         rec = 1'b0;
    logic         din_rec[$];
    logic         dout_rec[$];

    // Reference model: 0 = waiting for a reset gap, 1 = idle, 2 = inside a frame
    int           m_state = 0;
    int           m_idx   = 0;
    int           m_fe    = 0;
    logic         m_ovf   = 1'b0;
    logic         m_err   = 1'b0;
    logic         m_pend  = 1'b0;
    logic [W-1:0] m_pix   = '0;

    always @(negedge clk) begin
        if (pixel_valid && pixel_ready) acc_q.push_back(pixel);
        if (frame_end) fe_cnt++;
        if (dout) dout_hi++;
        if (rec) begin
            din_rec.push_back(din);
            dout_rec.push_back(dout);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic hold(input logic v, input int n);
        din = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_word(input logic [W-1:0] w);
        if (m_state != 0) begin
            m_state = 2;
            if (m_pend && !pixel_ready) m_ovf = 1'b1;
            m_pix  = w;
            m_pend = 1'b1;
            if (m_idx < 511) m_idx++;
            if (pixel_ready) begin
                exp_q.push_back(w);
                m_pend = 1'b0;
            end
        end
    endtask

    task automatic gap;
        hold(1'b0, GAP);
        if (m_state == 2) begin
            m_fe++;
            m_idx = 0;
        end
        m_state = 1;
    endtask

    task automatic set_ready(input logic v);
        pixel_ready = v;
        if (v && m_pend) begin
            exp_q.push_back(m_pix);
            m_pend = 1'b0;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    // mode: 0 random timing, 1 nominal timing, 2 random plus one glitch, 3 threshold widths
    task automatic send_word(input logic [W-1:0] w, input int mode);
        int g = $urandom_range(0, W - 1);
        for (int i = 0; i < W; i++) begin
            int hi;
            int lo;
            lo = $urandom_range(4, 20);
            if (mode == 1) begin
                hi = w[i] ? 23 : 11;
                lo = w[i] ? 11 : 23;
            end else if (mode == 3) begin
                if (w[i]) hi = ($urandom_range(0, 1) != 0) ? 16 : 54;
                else      hi = ($urandom_range(0, 1) != 0) ? 2 : 15;
            end else begin
                hi = w[i] ? $urandom_range(18, 50) : $urandom_range(3, 13);
            end
            hold(1'b1, hi);
            if (mode == 2 && i == g) begin
                hold(1'b0, 3);
                hold(1'b1, 1);
            end
            hold(1'b0, lo);
        end
        model_word(w);
    endtask

    task automatic check_status(input string tag);
        check_eq({tag, ".pixel"}, pixel, m_pix);
        check_eq({tag, ".valid"}, pixel_valid, m_pend);
        check_eq({tag, ".idx"}, pixel_idx, m_idx);
        check_eq({tag, ".overflow"}, overflow, m_ovf);
        check_eq({tag, ".bit_err"}, bit_err, m_err);
        check_eq({tag, ".frame_ends"}, fe_cnt, m_fe);
    endtask

    task automatic check_accepts(input string tag);
        int n;
        check_eq({tag, ".accept_count"}, acc_q.size(), exp_q.size());
        n = (acc_q.size() < exp_q.size()) ? acc_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check_eq({tag, ".accept_word"}, acc_q[i], exp_q[i]);
        acc_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int n;
        int mism;
        int w1_len;
        logic [W-1:0] w;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_status("reset");
        check_eq("reset.frame_end", frame_end, 0);
        check_eq("reset.dout", dout, 0);

        // Nominal single word, held unconsumed
        gap;
        send_word(24'hA5_3C_0F, 1);
        check_status("single");
        set_ready(1'b1);
        check_status("single_acc");
        check_accepts("single");

        // Three streamed words then a reset gap
        for (int i = 0; i < 3; i++) send_word(W'($urandom), 0);
        gap;
        check_status("three");
        check_accepts("three");

        // Consumer stalled across two words
        pixel_ready = 1'b0;
        send_word(W'($urandom), 0);
        send_word(W'($urandom), 0);
        check_status("ovf");
        set_ready(1'b1);
        check_accepts("ovf");
        gap;

        // Glitch, threshold widths, over-long high
        send_word(W'($urandom), 2);
        check_status("glitch");
        send_word(W'($urandom), 3);
        check_status("thresh");
        hold(1'b1, 60);
        hold(1'b0, 10);
        m_err   = 1'b1;
        m_state = 0;
        send_word(W'($urandom), 0);
        check_status("err_sync");
        gap;
        check_status("err_resync");
        send_word(W'($urandom), 0);
        gap;
        check_status("err_recover");
        check_accepts("err");

        // Reset asserted partway through a word
        for (int i = 0; i < 12; i++) begin
            n = $urandom_range(0, 1);
            hold(1'b1, (n != 0) ? 22 : 8);
            hold(1'b0, 10);
        end
        hold(1'b1, 3);
        rst = 1'b1;
        hold(1'b1, 3);
        rst = 1'b0;
        hold(1'b0, 5);
        m_state = 0;
        m_idx   = 0;
        m_ovf   = 1'b0;
        m_err   = 1'b0;
        m_pend  = 1'b0;
        m_pix   = '0;
        check_status("midrst");
        gap;
        send_word(24'h00_00_01, 0);
        check_status("midrst_word");
        gap;
        check_accepts("midrst");

        // Random frames
        for (int f = 0; f < 4; f++) begin
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) send_word(W'($urandom), 0);
            check_status("rand_frame");
            gap;
            check_accepts("rand_frame");
        end
        check_status("rand_end");

`ifdef WS2812_RX_FWD_EN
        rec = 1'b1;
        send_word(W'($urandom), 0);
        w1_len = din_rec.size();
        send_word(W'($urandom), 0);
        hold(1'b0, 10);
        rec = 1'b0;
        gap;
        mism = 0;
        for (int k = 0; k < dout_rec.size(); k++) begin
            logic e;
            e = (k >= w1_len && k >= 3) ? din_rec[k - 3] : 1'b0;
            if (dout_rec[k] !== e) mism++;
        end
        check_eq("fwd_wave_mismatches", mism, 0);
        check_accepts("fwd");
`else
        w1_len = 0;
        mism   = dout_hi;
        check_eq("dout_high_cycles", mism, w1_len);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ws2812_rx.md
WS2812_RX -- requirements
Module: ws2812_rx

Interface
REQ-001 SHALL have parameter CLK_FRE, default 27_000_000, clock frequency in Hz.
REQ-002 SHALL have parameter WS2812_WIDTH, default 24, bits per pixel word.
REQ-003 SHALL have parameter T_THRESH, default CLK_FRE/1_000_000*6/10 (16 cycles), high-time threshold separating 0 from 1.
REQ-004 SHALL have parameter T_MIN_HIGH, default CLK_FRE/10_000_000 (2 cycles); shorter high pulses are glitches.
REQ-005 SHALL have parameter T_MAX_HIGH, default CLK_FRE/1_000_000*2 (54 cycles); longer high pulses are errors.
REQ-006 SHALL have parameter T_RESET, default CLK_FRE/1_000_000*50 (1350 cycles), low time that ends a frame.
REQ-007 SHALL have port clk input 1, sole clock; all logic on rising edge.
REQ-008 SHALL have port rst input 1, reset, asynchronous, active-high.
REQ-009 SHALL have port din input 1, asynchronous WS2812 serial line.
REQ-010 SHALL have port pixel output WS2812_WIDTH, last complete pixel word.
REQ-011 SHALL have port pixel_valid output 1, pixel holds an unconsumed word.
REQ-012 SHALL have port pixel_ready input 1, consumer accepts word when high with pixel_valid.
REQ-013 SHALL have port pixel_idx output 9, index of pixel word within current frame (0-based).
REQ-014 SHALL have port frame_end output 1, one-cycle pulse on reset-gap detection.
REQ-015 SHALL have ports overflow and bit_err, output 1 each, sticky error flags.
REQ-016 SHALL have port dout output 1, forwarded line (see Configuration).

Function
REQ-017 SHALL pass din through a 2-flop synchronizer; all timing uses the synchronized value (2-cycle input latency).
REQ-018 SHALL implement states SYNC (wait for T_RESET continuous low), IDLE, HIGH (count high time), LOW (count low time).
REQ-019 SYNC -> IDLE once low count reaches T_RESET; any high in SYNC restarts the count.
REQ-020 IDLE/LOW -> HIGH on rising edge; high counter starts at 1 on the first high cycle.
REQ-021 On falling edge in HIGH: count < T_MIN_HIGH -> discard, no bit; count >= T_THRESH -> bit 1; else bit 0; then -> LOW.
REQ-022 HIGH count exceeding T_MAX_HIGH SHALL set bit_err, discard the partial word, -> SYNC.
REQ-023 Bits SHALL shift in LSB first: first bit of a word lands in bit 0, matching the codebase transmitter.
REQ-024 On the WS2812_WIDTHth bit, the word SHALL load into pixel and pixel_valid SHALL rise the next cycle; bit counter clears.
REQ-025 Word transfer occurs when pixel_valid and pixel_ready are both high; pixel_valid clears next cycle unless a new word loads in the same cycle.
REQ-026 A word completing while pixel_valid=1 and pixel_ready=0 SHALL set overflow and overwrite pixel; pixel_valid stays 1.
REQ-027 pixel_idx SHALL increment after each completed word, saturate at 511, clear on frame_end.
REQ-028 LOW count reaching T_RESET SHALL pulse frame_end once, discard any partial word (no bit_err), -> IDLE.
REQ-029 overflow and bit_err SHALL clear only on reset.

Reset
REQ-030 On rst: state SYNC, counters 0, pixel 0, pixel_valid 0, pixel_idx 0, frame_end 0, overflow 0, bit_err 0, dout 0.
REQ-031 Assertion mid-bit or mid-word SHALL discard all partial data; after release the block re-qualifies a full T_RESET gap.

Configuration
REQ-032 With WS2812_RX_FWD_EN defined, dout SHALL equal synchronized din delayed one cycle, gated low for the first word of each frame and following bits until frame_end (chained-LED daisy-chain behaviour).
REQ-033 Without WS2812_RX_FWD_EN, dout SHALL be constant 0 and the forwarding logic SHALL be absent.

Verification
REQ-034 Reset, 1350-cycle low, one word 24'hA5_3C_0F (LSB first, 1=23 high/11 low, 0=11 high/23 low) -> pixel=24'hA5_3C_0F, pixel_valid=1, pixel_idx=1.
REQ-035 Three words, pixel_ready held 1, then 1350-cycle low -> three accepts, no overflow, one frame_end pulse, pixel_idx=0.
REQ-036 Two words with pixel_ready=0 -> overflow=1, pixel=second word, pixel_valid=1.
REQ-037 1-cycle high glitch inside a word -> ignored, word decodes correctly; 60-cycle high -> bit_err=1, state SYNC, no pixel_valid.
REQ-038 rst pulse after 12 bits, then gap plus full word 24'h00_00_01 -> pixel=24'h00_00_01, pixel_idx=1.
REQ-039 WS2812_RX_FWD_EN: two words -> dout low during word 1, replicates word 2 waveform one cycle late; macro undefined -> dout stays 0.
